cu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the control unit. Owns the 4-bit state register, runs FETCH, classifies the instruction in IR, and routes the selected per-class decoder's control word, k_mux and next-state code to the datapath. It sits between the instruction register and the per-class decoders (immediate, register, memory, branch). It adds memory-ready stalls, halt, and a sticky fault state.

---
 rtl/cu_pkg.sv | 50 +++++
 rtl/cu_class_decode.sv | 36 +++
 rtl/cu_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_cu_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the control-unit sequencer.
// Holds the state and class encodings, the control-word field indices,
// and the two fixed control words (FETCH_CW, NOP_CW).
package cu_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CW_W    = 37;
  localparam int unsigned NS_W    = 3;
  localparam int unsigned KM_W    = 3;

  // Sequencer states
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH = 4'b0000,
    ST_EX0   = 4'b0001,
    ST_EX1   = 4'b0010,
    ST_EX2   = 4'b0011,
    ST_HALT  = 4'b1110,
    ST_FAULT = 4'b1111
  } state_e;

  // Instruction classes: bit positions in the one-hot class vector
  localparam int unsigned CLS_N   = 4;
  localparam int unsigned CLS_IMM = 0;
  localparam int unsigned CLS_REG = 1;
  localparam int unsigned CLS_MEM = 2;
  localparam int unsigned CLS_BR  = 3;

  // Control-word field positions (LSB of multi-bit fields)
  localparam int unsigned PC_FS_LSB        = 0;
  localparam int unsigned PC_SEL_BIT       = 2;
  localparam int unsigned DATA_TRI_LSB     = 3;
  localparam int unsigned ADD_TRI_BIT      = 5;
  localparam int unsigned SIZE_LSB         = 6;
  localparam int unsigned STATUS_LOAD_BIT  = 8;
  localparam int unsigned IR_LOAD_BIT      = 9;
  localparam int unsigned MEM_WRITE_EN_BIT = 10;
  localparam int unsigned B_SEL_BIT        = 11;
  localparam int unsigned MEM_CS_LSB       = 12;
  localparam int unsigned C0_BIT           = 14;
  localparam int unsigned W_REG_BIT        = 15;
  localparam int unsigned DA_LSB           = 16;
  localparam int unsigned SB_LSB           = 21;
  localparam int unsigned SA_LSB           = 26;
  localparam int unsigned FS_LSB           = 31;

  // Fetch: memory chip-select only; IR_load/PC_FS are added when memory is ready
  localparam logic [CW_W-1:0] FETCH_CW = CW_W'(1) << MEM_CS_LSB;
  localparam logic [CW_W-1:0] NOP_CW   = '0;

endpackage

// File: rtl/cu_class_decode.sv
// Instruction class decoder: maps IR to a one-hot class vector plus an
// illegal flag, first match wins (imm, br, mem, reg).
// Ports:
//   ir_i         instruction register contents
//   cls_c_o      one-hot class (index constants in cu_pkg)
//   illegal_c_o  no class matched
module cu_class_decode
  import cu_pkg::*;
(
  input  logic [31:0]      ir_i,
  output logic [CLS_N-1:0] cls_c_o,
  output logic             illegal_c_o
);

  // Only IR[28:25] takes part in classification
  logic unused_ir;
  assign unused_ir = ^{ir_i[31:29], ir_i[24:0]};

  // Priority classification
  always_comb begin
    cls_c_o     = '0;
    illegal_c_o = 1'b0;
    if (ir_i[28:26] == 3'b100) begin
      cls_c_o[CLS_IMM] = 1'b1;
    end else if (ir_i[28:26] == 3'b101) begin
      cls_c_o[CLS_BR] = 1'b1;
    end else if (ir_i[27] && !ir_i[25]) begin
      cls_c_o[CLS_MEM] = 1'b1;
    end else if (ir_i[27:25] == 3'b101) begin
      cls_c_o[CLS_REG] = 1'b1;
    end else begin
      illegal_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle instruction sequencer: runs FETCH, classifies IR, routes the
// selected class decoder's control word / k_mux / next-state code, and adds
// memory-ready stalls, halt, a watchdog and a sticky fault state.
// Ports:
//   clock, reset          clock, async active-high reset
//   IR                    instruction register
//   mem_ready, halt_req   memory handshake, halt request (sampled in FETCH)
//   cw_*/ns_*/km_*        per-class control word, next-state code, k_mux
//   state                 registered state, fed back to the class decoders
//   controlWord, k_mux    combinational datapath controls
//   fault, halted         registered status
// Optional feature: define CU_SEQ_PERF_EN to add retired_cnt and stall_cnt.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned CUL    = 36,
  parameter int unsigned MAX_EX = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        IR,
  input  logic               mem_ready,
  input  logic               halt_req,
  input  logic [CUL:0]       cw_imm,
  input  logic [CUL:0]       cw_reg,
  input  logic [CUL:0]       cw_mem,
  input  logic [CUL:0]       cw_br,
  input  logic [NS_W-1:0]    ns_imm,
  input  logic [NS_W-1:0]    ns_reg,
  input  logic [NS_W-1:0]    ns_mem,
  input  logic [NS_W-1:0]    ns_br,
  input  logic [KM_W-1:0]    km_imm,
  input  logic [KM_W-1:0]    km_reg,
  input  logic [KM_W-1:0]    km_mem,
  input  logic [KM_W-1:0]    km_br,
  output logic [STATE_W-1:0] state,
  output logic [CUL:0]       controlWord,
  output logic [KM_W-1:0]    k_mux,
  output logic               fault,
  output logic               halted
`ifdef CU_SEQ_PERF_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int unsigned CWW = CUL + 1;
  localparam int unsigned EXW = $clog2(MAX_EX + 1);

  state_e           state_q, state_d;
  logic [EXW-1:0]   ex_cnt_q, ex_cnt_d;
  logic             fault_q, halted_q;

  logic [CLS_N-1:0] cls_c;
  logic             illegal_c;
  logic [CWW-1:0]   sel_cw_c;
  logic [NS_W-1:0]  sel_ns_c;
  logic [KM_W-1:0]  sel_km_c;
  logic [CWW-1:0]   cw_c;
  logic [KM_W-1:0]  km_c;
  logic             ex_last_c;
  logic             stall_c;
  logic             retire_c;

  cu_class_decode u_class_decode (
    .ir_i        (IR),
    .cls_c_o     (cls_c),
    .illegal_c_o (illegal_c)
  );

  // Class input select
  always_comb begin
    sel_cw_c = cw_reg;
    sel_ns_c = ns_reg;
    sel_km_c = km_reg;
    if (cls_c[CLS_IMM]) begin
      sel_cw_c = cw_imm;
      sel_ns_c = ns_imm;
      sel_km_c = km_imm;
    end else if (cls_c[CLS_BR]) begin
      sel_cw_c = cw_br;
      sel_ns_c = ns_br;
      sel_km_c = km_br;
    end else if (cls_c[CLS_MEM]) begin
      sel_cw_c = cw_mem;
      sel_ns_c = ns_mem;
      sel_km_c = km_mem;
    end
  end

  // Current EX cycle is the last one the watchdog allows
  assign ex_last_c = (ex_cnt_q >= EXW'(MAX_EX - 1));

  // Next state and combinational datapath controls
  always_comb begin
    state_d  = state_q;
    ex_cnt_d = '0;
    cw_c     = CWW'(NOP_CW);
    km_c     = '0;
    stall_c  = 1'b0;
    retire_c = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (halt_req) begin
          // Halt wins over a completing fetch: nothing is issued
          state_d = ST_HALT;
        end else begin
          cw_c = CWW'(FETCH_CW);
          if (mem_ready) begin
            cw_c[IR_LOAD_BIT]       = 1'b1;
            cw_c[PC_FS_LSB +: 2]    = 2'b01;
            state_d                 = ST_EX0;
          end else begin
            stall_c = 1'b1;
          end
        end
      end
      ST_EX0, ST_EX1, ST_EX2: begin
        ex_cnt_d = ex_cnt_q + EXW'(1);
        if (illegal_c) begin
          state_d = ST_FAULT;
        end else begin
          cw_c = sel_cw_c;
          km_c = sel_km_c;
          if ((sel_cw_c[MEM_CS_LSB +: 2] != 2'b00) && !mem_ready) begin
            // Memory stall: hold and suppress architectural side effects
            stall_c                 = 1'b1;
            cw_c[W_REG_BIT]         = 1'b0;
            cw_c[STATUS_LOAD_BIT]   = 1'b0;
            cw_c[IR_LOAD_BIT]       = 1'b0;
            cw_c[PC_FS_LSB +: 2]    = 2'b00;
          end else begin
            case (sel_ns_c)
              3'd0: begin
                state_d  = ST_FETCH;
                retire_c = !ex_last_c;
              end
              3'd1:    state_d = ST_EX0;
              3'd2:    state_d = ST_EX1;
              3'd3:    state_d = ST_EX2;
              default: state_d = ST_FAULT;
            endcase
          end
          // Watchdog overrides everything, stalls included
          if (ex_last_c) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_HALT: begin
        if (!halt_req) begin
          state_d = ST_FETCH;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // State and status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      ex_cnt_q <= '0;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ex_cnt_q <= ex_cnt_d;
      fault_q  <= (state_d == ST_FAULT);
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign state       = state_q;
  assign controlWord = cw_c;
  assign k_mux       = km_c;
  assign fault       = fault_q;
  assign halted      = halted_q;

`ifdef CU_SEQ_PERF_EN
  logic [31:0] retired_cnt_q, stall_cnt_q;

  // Free-running performance counters, wrap modulo 2^32
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (retire_c) begin
        retired_cnt_q <= retired_cnt_q + 32'd1;
      end
      if (stall_c) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = retire_c ^ stall_c;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: the stimulus thread pushes the
// expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_cu_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        mem_ready, halt_req;
  logic [36:0] cw_imm, cw_reg, cw_mem, cw_br;
  logic [2:0]  ns_imm, ns_reg, ns_mem, ns_br;
  logic [2:0]  km_imm, km_reg, km_mem, km_br;
  logic [3:0]  state;
  logic [36:0] controlWord;
  logic [2:0]  k_mux;
  logic        fault, halted;
`ifdef CU_SEQ_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  localparam logic [3:0] S_FETCH = 4'b0000;
  localparam logic [3:0] S_EX0   = 4'b0001;
  localparam logic [3:0] S_EX1   = 4'b0010;
  localparam logic [3:0] S_EX2   = 4'b0011;
  localparam logic [3:0] S_HALT  = 4'b1110;
  localparam logic [3:0] S_FAULT = 4'b1111;

  localparam logic [36:0] CW_IMM      = 37'h00ABCD0102;
  localparam logic [36:0] CW_REG      = 37'h0055550044;
  localparam logic [36:0] CW_MEM      = 37'h001234B301;
  localparam logic [36:0] CW_MEM_STL  = 37'h0012343000;
  localparam logic [36:0] CW_BR       = 37'h000F0F0004;
  localparam logic [36:0] CW_FETCH    = 37'h0000001000;
  localparam logic [36:0] CW_FETCH_RD = 37'h0000001201;
  localparam logic [36:0] CW_NOP      = 37'h0;

  localparam logic [31:0] IR_IMM = 32'h91000421;
  localparam logic [31:0] IR_BR  = 32'h14000000;
  localparam logic [31:0] IR_MEM = 32'h08000000;
  localparam logic [31:0] IR_REG = 32'h0A000000;
  localparam logic [31:0] IR_ILL = 32'h00000000;

  typedef struct packed {
    logic [3:0]  st;
    logic [36:0] cw;
    logic [2:0]  km;
    logic        f;
    logic        h;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  cu_sequencer #(.CUL(36), .MAX_EX(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .IR          (IR),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
    .cw_imm      (cw_imm),
    .cw_reg      (cw_reg),
    .cw_mem      (cw_mem),
    .cw_br       (cw_br),
    .ns_imm      (ns_imm),
    .ns_reg      (ns_reg),
    .ns_mem      (ns_mem),
    .ns_br       (ns_br),
    .km_imm      (km_imm),
    .km_reg      (km_reg),
    .km_mem      (km_mem),
    .km_br       (km_br),
    .state       (state),
    .controlWord (controlWord),
    .k_mux       (k_mux),
    .fault       (fault),
    .halted      (halted)
`ifdef CU_SEQ_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input string fld,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: compare the DUT outputs of this cycle against the next expectation
  exp_t  m_e;
  string m_nm;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      chk(m_nm, "state",  64'(state),       64'(m_e.st));
      chk(m_nm, "cw",     64'(controlWord), 64'(m_e.cw));
      chk(m_nm, "k_mux",  64'(k_mux),       64'(m_e.km));
      chk(m_nm, "fault",  64'(fault),       64'(m_e.f));
      chk(m_nm, "halted", 64'(halted),      64'(m_e.h));
    end
  end

  // Queue the expectation for the current cycle, then advance one clock
  task automatic step(input logic [3:0] st, input logic [36:0] cw,
                      input logic [2:0] km, input logic f, input logic h,
                      input string nm);
    exp_t e;
    e = '{st: st, cw: cw, km: km, f: f, h: h};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;  IR = IR_IMM;  mem_ready = 1'b0;  halt_req = 1'b0;
    cw_imm = CW_IMM;  cw_reg = CW_REG;  cw_mem = CW_MEM;  cw_br = CW_BR;
    ns_imm = 3'd0;  ns_reg = 3'd0;  ns_mem = 3'd0;  ns_br = 3'd0;
    km_imm = 3'd1;  km_reg = 3'd2;  km_mem = 3'd3;  km_br = 3'd5;
    repeat (2) @(posedge clock);
    #1;
    step(S_FETCH, CW_FETCH, 3'd0, 1'b0, 1'b0, "reset");
    reset = 1'b0;  mem_ready = 1'b1;

    // ADDI: two-cycle instruction
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "addi_fetch");
    step(S_EX0,   CW_IMM,      3'd1, 1'b0, 1'b0, "addi_ex0");
    // MOVK-style: EX0 -> EX1 -> FETCH
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "movk_fetch");
    ns_imm = 3'd2;
    step(S_EX0,   CW_IMM,      3'd1, 1'b0, 1'b0, "movk_ex0");
    ns_imm = 3'd0;
    step(S_EX1,   CW_IMM,      3'd1, 1'b0, 1'b0, "movk_ex1");

    // Fetch with three wait cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      step(S_FETCH, CW_FETCH, 3'd0, 1'b0, 1'b0, "fetch_wait");
    mem_ready = 1'b1;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "fetch_done");
    step(S_EX0,   CW_IMM,      3'd1, 1'b0, 1'b0, "fetch_ex0");

    // Memory-class execute stalled for two cycles
    IR = IR_MEM;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "mem_fetch");
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      step(S_EX0, CW_MEM_STL, 3'd3, 1'b0, 1'b0, "mem_stall");
    mem_ready = 1'b1;
    step(S_EX0,   CW_MEM,      3'd3, 1'b0, 1'b0, "mem_go");

    // Halt requested during EX0; halt wins over a ready fetch
    IR = IR_IMM;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "halt_fetch");
    halt_req = 1'b1;
    step(S_EX0,   CW_IMM,      3'd1, 1'b0, 1'b0, "halt_ex0");
    step(S_FETCH, CW_NOP,      3'd0, 1'b0, 1'b0, "halt_wins");
    step(S_HALT,  CW_NOP,      3'd0, 1'b0, 1'b1, "halt_hold");
    halt_req = 1'b0;
    step(S_HALT,  CW_NOP,      3'd0, 1'b0, 1'b1, "halt_release");
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "halt_resume");
    step(S_EX0,   CW_IMM,      3'd1, 1'b0, 1'b0, "resume_ex0");

    // Branch class through EX2
    IR = IR_BR;  ns_br = 3'd3;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "br_fetch");
    step(S_EX0,   CW_BR,       3'd5, 1'b0, 1'b0, "br_ex0");
    ns_br = 3'd0;
    step(S_EX2,   CW_BR,       3'd5, 1'b0, 1'b0, "br_ex2");

    // Register class
    IR = IR_REG;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "reg_fetch");
    step(S_EX0,   CW_REG,      3'd2, 1'b0, 1'b0, "reg_ex0");

    // Next-state code above 3 faults
    ns_reg = 3'd5;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "ns5_fetch");
    step(S_EX0,   CW_REG,      3'd2, 1'b0, 1'b0, "ns5_ex0");
    step(S_FAULT, CW_NOP,      3'd0, 1'b1, 1'b0, "ns5_fault");
    reset = 1'b1;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "ns5_reset");
    reset = 1'b0;

    // Watchdog: looping EX0 faults after four EX cycles
    IR = IR_IMM;  ns_imm = 3'd1;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "wd_fetch");
    for (int i = 0; i < 4; i++)
      step(S_EX0, CW_IMM, 3'd1, 1'b0, 1'b0, "wd_ex");
    step(S_FAULT, CW_NOP,      3'd0, 1'b1, 1'b0, "wd_fault");
    reset = 1'b1;  ns_imm = 3'd0;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "wd_reset");
    reset = 1'b0;

    // Illegal instruction: sticky fault, ignores halt_req, cleared only by reset
    IR = IR_ILL;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "ill_fetch");
    step(S_EX0,   CW_NOP,      3'd0, 1'b0, 1'b0, "ill_ex0");
    step(S_FAULT, CW_NOP,      3'd0, 1'b1, 1'b0, "ill_fault");
    halt_req = 1'b1;
    step(S_FAULT, CW_NOP,      3'd0, 1'b1, 1'b0, "ill_sticky");
    halt_req = 1'b0;  reset = 1'b1;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "ill_reset");
    reset = 1'b0;

    // Reset during a stalled memory instruction abandons it
    IR = IR_MEM;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "abort_fetch");
    mem_ready = 1'b0;
    step(S_EX0,   CW_MEM_STL,  3'd3, 1'b0, 1'b0, "abort_stall");
    reset = 1'b1;
    step(S_FETCH, CW_FETCH,    3'd0, 1'b0, 1'b0, "abort_reset");
    reset = 1'b0;  mem_ready = 1'b1;
    step(S_FETCH, CW_FETCH_RD, 3'd0, 1'b0, 1'b0, "abort_refetch");
    step(S_EX0,   CW_MEM,      3'd3, 1'b0, 1'b0, "abort_ex0");

    // Every queued expectation must have been consumed by the monitor
    @(negedge clock);
    chk("drain", "pending", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
